// File: rtl/conv_cfg_pkg.sv
// ---------------------------------------------------------------------------
// conv_cfg_pkg : conv layer weight-bus address map and element types. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv_cfg_pkg;

  typedef logic signed [7:0]  weight_t;
  typedef logic signed [31:0] bias_t;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_KERNEL = 2'd1,
    REG_BIAS   = 2'd2,
    REG_COEFF  = 2'd3
  } region_e;

  function automatic int kw_of(input int k0, input int k1, input int ic);
    return k0 * k1 * ic;
  endfunction

  function automatic int nk_of(input int k0, input int k1, input int ic, input int oc);
    return kw_of(k0, k1, ic) * oc;
  endfunction

  function automatic int bias_base_of(input int base, input int k0, input int k1,
                                      input int ic, input int oc);
    return base + nk_of(k0, k1, ic, oc);
  endfunction

  function automatic int coeff_addr_of(input int base, input int k0, input int k1,
                                       input int ic, input int oc);
    return bias_base_of(base, k0, k1, ic, oc) + oc;
  endfunction

  function automatic int total_of(input int k0, input int k1, input int ic, input int oc);
    return nk_of(k0, k1, ic, oc) + oc + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_addr_decode.sv
// ---------------------------------------------------------------------------
// weight_addr_decode : bus address to layer region / channel / position. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module weight_addr_decode
  import conv_cfg_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3,
  parameter int IN_CHANNEL  = 3,
  parameter int OUT_CHANNEL = 16,
  parameter int OCW         = 4,
  parameter int PW          = 5
) (
  input  logic [31:0]    addr_i,
  output region_e        region_o,
  output logic [OCW-1:0] oc_o,
  output logic [PW-1:0]  p_o,
  output logic [OCW-1:0] bias_idx_o,
  output logic           hit_o
);

  localparam int KW  = kw_of(KERNEL_0, KERNEL_1, IN_CHANNEL);
  localparam int NK  = nk_of(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
  localparam int KOW = $clog2(NK + 1);

  logic [31:0]    w_off;
  logic [KOW-1:0] w_off_k;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of every region.
  assign w_off   = addr_i - 32'(BASE_ADDR);
  assign w_off_k = KOW'(w_off);

  always_comb begin
    region_o = REG_NONE;
    if (w_off < 32'(NK))                    region_o = REG_KERNEL;
    else if (w_off < 32'(NK + OUT_CHANNEL)) region_o = REG_BIAS;
    else if (w_off == 32'(NK + OUT_CHANNEL)) region_o = REG_COEFF;
  end

  assign hit_o      = (region_o != REG_NONE);
  assign oc_o       = OCW'(w_off_k / KOW'(KW));
  assign p_o        = PW'(w_off_k % KOW'(KW));
  assign bias_idx_o = OCW'(w_off - 32'(NK));

endmodule

`default_nettype wire

// File: rtl/conv_weight_bank.sv
// ---------------------------------------------------------------------------
// conv_weight_bank : per-layer weight/bias/coeff store on the load bus. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_weight_bank
  import conv_cfg_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3,
  parameter int IN_CHANNEL  = 3,
  parameter int OUT_CHANNEL = 16,
  parameter int COEFF_W     = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [31:0]                                  weight_wr_data,
  input  logic [31:0]                                  weight_wr_addr,
  input  logic                                         weight_wr_en,
  input  logic                                         clr,
  input  logic                                         rd_en,
  input  logic [$clog2(OUT_CHANNEL)-1:0]               rd_oc,
  output logic [8*KERNEL_0*KERNEL_1*IN_CHANNEL-1:0]    o_kernel,
  output logic [31:0]                                  o_bias,
  output logic [COEFF_W-1:0]                           o_coeff,
  output logic                                         o_rd_valid,
  output logic                                         o_wr_ack,
  output logic                                         o_loaded
);

  localparam int KW    = kw_of(KERNEL_0, KERNEL_1, IN_CHANNEL);
  localparam int TOTAL = total_of(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
  localparam int OCW   = $clog2(OUT_CHANNEL);
  localparam int PW    = $clog2(KW);
  localparam int TW    = $clog2(TOTAL);
  localparam int KV    = 8 * KW;

  region_e        w_region;
  logic [OCW-1:0] w_oc;
  logic [OCW-1:0] w_bias_idx;
  logic [PW-1:0]  w_p;
  logic           w_hit;
  logic           w_wr;
  logic           w_rd_in_range;
  logic [TW-1:0]  w_map_idx;

  weight_t [KW-1:0]   kern_mem_q [OUT_CHANNEL];
  bias_t              bias_mem_q [OUT_CHANNEL];
  logic [COEFF_W-1:0] coeff_mem_q;

  logic [TOTAL-1:0]   map_q, map_d;
  logic               loaded_q;
  logic               ack_q;
  logic               valid_q;
  logic [KV-1:0]      kern_q;
  logic [31:0]        bias_q;
  logic [COEFF_W-1:0] coeff_q;

  weight_addr_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .KERNEL_0    (KERNEL_0),
    .KERNEL_1    (KERNEL_1),
    .IN_CHANNEL  (IN_CHANNEL),
    .OUT_CHANNEL (OUT_CHANNEL),
    .OCW         (OCW),
    .PW          (PW)
  ) u_decode (
    .addr_i     (weight_wr_addr),
    .region_o   (w_region),
    .oc_o       (w_oc),
    .p_o        (w_p),
    .bias_idx_o (w_bias_idx),
    .hit_o      (w_hit)
  );

  assign w_wr      = weight_wr_en && w_hit && !rst;
  assign w_map_idx = TW'(weight_wr_addr - 32'(BASE_ADDR));

  generate
    if (OUT_CHANNEL == (1 << OCW)) begin : g_full_range
      assign w_rd_in_range = 1'b1;
    end else begin : g_partial_range
      assign w_rd_in_range = (rd_oc < OCW'(OUT_CHANNEL));
    end
  endgenerate

  // RAM-style storage: never reset, only the bitmap tracks validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      unique case (w_region)
        REG_KERNEL: kern_mem_q[w_oc][w_p]   <= weight_t'(weight_wr_data[7:0]);
        REG_BIAS:   bias_mem_q[w_bias_idx]  <= bias_t'(weight_wr_data);
        REG_COEFF:  coeff_mem_q             <= weight_wr_data[COEFF_W-1:0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    map_d = map_q;
    if (w_wr) map_d[w_map_idx] = 1'b1;
    if (clr)  map_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q    <= '0;
      loaded_q <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      kern_q   <= '0;
      bias_q   <= '0;
      coeff_q  <= '0;
    end else begin
      map_q    <= map_d;
      loaded_q <= clr ? 1'b0 : &map_q;
      ack_q    <= w_wr;
      valid_q  <= rd_en;
      // Non-blocking reads of the arrays give read-before-write on collisions.
      if (rd_en) begin
        kern_q  <= w_rd_in_range ? kern_mem_q[rd_oc] : '0;
        bias_q  <= w_rd_in_range ? bias_mem_q[rd_oc] : '0;
        coeff_q <= w_rd_in_range ? coeff_mem_q       : '0;
      end
    end
  end

  assign o_kernel   = kern_q;
  assign o_bias     = bias_q;
  assign o_coeff    = coeff_q;
  assign o_rd_valid = valid_q;
  assign o_wr_ack   = ack_q;
  assign o_loaded   = loaded_q;

endmodule

`default_nettype wire
